// File: rtl/reg8_scan_src.sv
// ============================================================================
// reg8_scan_src : writable 8-entry register bank feeding an 8:1 mux, plus a
//                 sequenced channel selector (auto-scan or single-step).
// Revision      : 1.0
// ============================================================================
`default_nettype none

module reg8_scan_src #(
  parameter int WIDTH = 8,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [2:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             scan_en,
  input  logic             step,
  output logic [WIDTH-1:0] x0,
  output logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] x2,
  output logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] x4,
  output logic [WIDTH-1:0] x5,
  output logic [WIDTH-1:0] x6,
  output logic [WIDTH-1:0] x7,
  output logic [2:0]       sel,
  output logic             busy,
  output logic             wrap
);

  localparam logic [7:0] c_DWELL_M1 = 8'(DWELL - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nxt;
  logic             w_adv;
  logic [2:0]       r_sel;
  logic             r_busy;
  logic             r_wrap;
  logic [WIDTH-1:0] r_regs [0:7];

  // Reset pattern: channel index repeated in every nibble, truncated to WIDTH.
  function automatic logic [WIDTH-1:0] f_rst_val(input logic [2:0] n);
    logic [WIDTH-1:0] v;
    logic [3:0]       nib;
    nib = {1'b0, n};
    for (int b = 0; b < WIDTH; b++) begin
      v[b] = nib[2'(b % 4)];
    end
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= f_rst_val(3'(i));
      end
    end else if (we) begin
      r_regs[waddr] <= wdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_adv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (scan_en) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = 8'd0;
        end else if (step) begin
          w_adv = 1'b1;
        end
      end
      S_RUN: begin
        // Dropping scan_en stops without advancing, even on the last dwell cycle.
        if (!scan_en) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end else if (r_cnt == c_DWELL_M1) begin
          w_cnt_nxt = 8'd0;
          w_adv     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_sel   <= 3'd0;
      r_busy  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_adv) begin
        r_sel <= r_sel + 3'd1;
      end
      r_busy  <= (w_state_nxt == S_RUN);
      r_wrap  <= w_adv && (r_sel == 3'd7);
    end
  end

  assign x0   = r_regs[0];
  assign x1   = r_regs[1];
  assign x2   = r_regs[2];
  assign x3   = r_regs[3];
  assign x4   = r_regs[4];
  assign x5   = r_regs[5];
  assign x6   = r_regs[6];
  assign x7   = r_regs[7];
  assign sel  = r_sel;
  assign busy = r_busy;
  assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: doc/reg8_scan_src.md
Name: reg8_scan_src

Overview:
Upstream source stage for the 8-to-1 x 8-bit output multiplexer. Holds eight WIDTH-bit data registers that drive the mux inputs x0..x7. Generates the 3-bit select, either auto-scanning all channels or single-stepping under control. Replaces the fixed test pattern and hand-driven select with a writable register bank and a sequenced selector.

Parameters:
WIDTH, 8, data width of each register and x output
DWELL, 4, clock cycles sel holds each channel in auto-scan; legal range 1..255

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
we  input  1  register write enable
waddr  input  3  register index to write
wdata  input  WIDTH  write data
scan_en  input  1  level: 1 = auto-scan, 0 = stop/hold
step  input  1  single-cycle pulse: advance sel by one (IDLE only)
x0..x7  output  WIDTH each  register contents, to mux x0..x7
sel  output  3  channel select, to mux sel
busy  output  1  1 while in RUN state
wrap  output  1  one-cycle pulse when sel advances 7 -> 0

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, rst_n). With rst_n=0 at a rising edge:
  - xN <= N*8'h11 (x0=00, x1=11 ... x7=77) for WIDTH=8; for other WIDTH, N replicated per nibble, truncated.
  - sel=0, busy=0, wrap=0, dwell counter=0, state=IDLE.
  - Reset dominates all other inputs, including mid-scan.
- Registers are all flopped; no combinational path from any input to any output.
- Write:
  - we=1 at an edge: reg[waddr] <= wdata; visible on xN after that edge (1-cycle latency).
  - Independent of state; allowed during RUN.
  - A write to the currently selected channel shows on that x output next cycle.
- State machine, IDLE/RUN:
  - IDLE, scan_en=1: -> RUN. cnt <= 0, sel unchanged, so the current channel is shown first for a full DWELL.
  - IDLE, scan_en=0, step=1: sel <= sel+1 mod 8, state stays IDLE.
  - IDLE, scan_en=1 and step=1 together: scan_en wins, step is ignored.
  - RUN, scan_en=1:
    - cnt < DWELL-1: cnt <= cnt+1.
    - cnt == DWELL-1: cnt <= 0, sel <= sel+1 mod 8.
    - step is ignored in RUN.
  - RUN, scan_en=0: -> IDLE, sel holds its current value, cnt <= 0. No advance on that edge, even if cnt == DWELL-1.
  - DWELL=1: sel advances on every RUN cycle.
- busy = (state==RUN), registered.
- wrap:
  - High for exactly the one cycle after any edge where sel goes 7 -> 0 (auto or step); low otherwise.
  - Reset never produces a wrap pulse.
- Counter is 8 bits wide. In RUN, sel holds each value for exactly DWELL cycles, and a full scan is 8*DWELL cycles.

Test Plan:
- Reset, then read: rst_n=0 for 2 cycles, release -> x0..x7 = 00,11,22,33,44,55,66,77; sel=0; busy=0; wrap=0.
- Write path: we=1, waddr=5, wdata=A5 for 1 cycle -> x5=A5 next cycle, others unchanged. Then waddr=0, wdata=3C -> x0=3C.
- Auto-scan, DWELL=4: scan_en=1 from sel=0 -> busy=1; sel sequence 0,1,...,7,0 with each value held 4 cycles. wrap high for 1 cycle when sel becomes 0 again, 32 cycles after scan start.
- Stop mid-scan: drop scan_en when sel=3 and cnt=2 -> busy=0 next cycle, sel stays 3. Re-raise scan_en -> sel=3 holds a full 4 cycles, then 4.
- Single-step and priority:
  - IDLE at sel=7, step pulse -> sel=0 and wrap pulse.
  - step and scan_en high together -> sel unchanged, busy=1.
  - step during RUN -> no extra advance.
- Reset mid-operation: RUN at sel=6 after x2 was written with FF, assert rst_n=0 for 1 cycle -> sel=0, busy=0, x2=22. Concurrent we=1 in the reset cycle is discarded.
